capp_controller: RTL and testbench
==================================

CAPP_CONTROLLER -- requirements
Module: capp_controller

Interface
REQ-001 Parameter WORDS, default 100, number of cell words driven.
REQ-002 Parameter WIDTH, default 32, bits per cell word.
REQ-003 Clock and reset SHALL be one clock and a synchronous, active-low reset: clk drives all state, and rst_n is sampled on the rising edge of clk.
REQ-004 clk  input  1  sole clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  controller idle and accepting commands.
REQ-008 cmd_op  input  2  command: 0 SEARCH, 1 WRITE, 2 READ_FIRST, 3 CLEAR_FIRST.
REQ-009 cmd_data  input  WIDTH  comparand for SEARCH, write data for WRITE.
REQ-010 cmd_mask  input  WIDTH  1 = bit participates; 0 = bit ignored or not written.
REQ-011 mismatch_lines  output  2*WIDTH  line 2j = search for 1 at bit j; line 2j+1 = search for 0 at bit j.
REQ-012 write_lines  output  2*WIDTH  line 2j = set bit j; line 2j+1 = clear bit j.
REQ-013 word_select  output  WORDS  one bit per word; gates writes and reads in the array.
REQ-014 match_lines  input  WORDS  array response; 1 = word mismatched.
REQ-015 read_lines  input  WIDTH  wired-OR data of the selected words.
REQ-016 resp_valid  output  1  single-cycle completion pulse.
REQ-017 resp_data  output  WIDTH  READ_FIRST data; 0 for all other commands.
REQ-018 resp_any  output  1  at least one tag is set after the command.
REQ-019 resp_count  output  7  number of set tags (see Configuration).

Function
REQ-020 Tag register tags[WORDS-1:0] SHALL hold the responders. Accept occurs on cmd_valid && cmd_ready. cmd_ready is high only in IDLE.
REQ-021 FSM states: IDLE, DRIVE, SAMPLE, RESP. Transitions are IDLE->DRIVE on accept, DRIVE->SAMPLE, SAMPLE->RESP, and RESP->IDLE.
REQ-022 Command fields SHALL be registered on accept, so later changes to cmd_* have no effect.
REQ-023 SEARCH, DRIVE and SAMPLE states: mismatch_lines[2j] = mask[j] & data[j], mismatch_lines[2j+1] = mask[j] & ~data[j]. In SAMPLE, tags <= ~match_lines.
REQ-024 WRITE, DRIVE state only: word_select = tags, write_lines[2j] = mask[j] & data[j], write_lines[2j+1] = mask[j] & ~data[j]. Tags are unchanged.
REQ-025 READ_FIRST, DRIVE and SAMPLE states: word_select = one-hot of the lowest-index set tag. resp_data <= read_lines, registered in SAMPLE. If no tag is set, word_select is 0 and resp_data is 0.
REQ-026 CLEAR_FIRST: in SAMPLE, the lowest-index set tag is cleared. With no tags set, this is a no-op.
REQ-027 Outside the states listed above, mismatch_lines, write_lines and word_select SHALL be 0.
REQ-028 resp_valid is high only in RESP, one cycle. Latency is accept edge to resp_valid equal to 3 cycles. resp_any and resp_count reflect tags after the update and hold until the next RESP.
REQ-029 A search with cmd_mask = 0 SHALL tag every word.

Reset
REQ-030 With rst_n low at an edge: state = IDLE, tags = 0, resp_data = 0, resp_any = 0, resp_count = 0, resp_valid = 0, and all line outputs = 0.
REQ-031 Reset mid-command SHALL abort the command with no resp_valid, and write_lines SHALL be 0 from the next cycle.

Configuration
REQ-032 Macro CAPP_RESP_COUNT_EN. When defined, resp_count = population count of tags, saturating at 127. When undefined, resp_count is tied to 0 and no popcount logic is built.

Structure
REQ-033 Package capp_pkg SHALL hold WORDS, WIDTH, the opcode enum, and the FSM state enum.
REQ-034 Sub-module capp_priority_resolver (input tags, outputs a lowest-set one-hot and a none flag) SHALL serve READ_FIRST and CLEAR_FIRST.

Verification
REQ-035 Array model preloaded with word0=456, word1=457, word4=1000, word5=457. SEARCH data=457, mask=all ones -> in SAMPLE, mismatch_lines pattern per REQ-023; resp_valid 3 cycles after accept; tags = {1,5}; resp_any = 1; resp_count = 2 (macro on).
REQ-036 After REQ-035: READ_FIRST -> word_select = bit1 only; resp_data = 457. Then CLEAR_FIRST, READ_FIRST -> resp_data = 457 from word 5.
REQ-037 SEARCH data=0xFFFFFFFF, mask=0 -> tags = all WORDS bits; resp_count = 100.
REQ-038 WRITE data=0, mask=0x1 with tags {1,5} -> write_lines = bit1 only, for exactly one cycle; word_select = {1,5}; tags unchanged.
REQ-039 SEARCH with no hits, then READ_FIRST -> word_select = 0, resp_data = 0, resp_any = 0.
REQ-040 Reset asserted in DRIVE of a WRITE -> no resp_valid; all outputs 0 next cycle; cmd_ready = 1 after reset release.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared types and sizing for the associative-array controller.
// Holds the default geometry, the command opcodes and the FSM states.
package capp_pkg;

    localparam int WORDS   = 100;
    localparam int WIDTH   = 32;
    localparam int COUNT_W = 7;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        OP_SEARCH      = 2'd0,
        OP_WRITE       = 2'd1,
        OP_READ_FIRST  = 2'd2,
        OP_CLEAR_FIRST = 2'd3
    } capp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_RESP
    } capp_state_e;

endpackage

// File: rtl/capp_controller_if.sv
// Command/response handshake plus the line bundle toward the cell array.
// slave = controller view, master = host/array view.
interface capp_controller_if #(
    parameter int WORDS = capp_pkg::WORDS,
    parameter int WIDTH = capp_pkg::WIDTH
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [WIDTH-1:0]       cmd_data;
    logic [WIDTH-1:0]       cmd_mask;
    logic [2*WIDTH-1:0]     mismatch_lines;
    logic [2*WIDTH-1:0]     write_lines;
    logic [WORDS-1:0]       word_select;
    logic [WORDS-1:0]       match_lines;
    logic [WIDTH-1:0]       read_lines;
    logic                   resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic                   resp_any;
    logic [6:0]             resp_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_mask, match_lines, read_lines,
        output cmd_ready, mismatch_lines, write_lines, word_select,
               resp_valid, resp_data, resp_any, resp_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_mask, match_lines, read_lines,
        input  cmd_ready, mismatch_lines, write_lines, word_select,
               resp_valid, resp_data, resp_any, resp_count
    );
endinterface

// File: rtl/capp_priority_resolver.sv
// Picks the lowest-index set tag as a one-hot vector; flags an empty tag set.
module capp_priority_resolver #(
    parameter int WORDS = capp_pkg::WORDS
) (
    input  logic [WORDS-1:0] tags,
    output logic [WORDS-1:0] first_onehot,
    output logic             none
);
    // Two's-complement trick isolates the least-significant set bit.
    assign first_onehot = tags & (~tags + WORDS'(1));
    assign none         = ~|tags;
endmodule

// File: rtl/capp_controller.sv
// Sequencer for a bit-line associative array: SEARCH, WRITE, READ_FIRST, CLEAR_FIRST.
// Optional macro CAPP_RESP_COUNT_EN builds a saturating popcount for resp_count.
module capp_controller
    import capp_pkg::*;
#(
    parameter int WORDS = capp_pkg::WORDS,
    parameter int WIDTH = capp_pkg::WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    capp_controller_if.slave bus
);
    capp_state_e        state, state_next;
    capp_op_e           op_q;
    logic [WIDTH-1:0]   data_q, mask_q, resp_data_q;
    logic [WORDS-1:0]   tags, tags_next, first_onehot;
    logic               tags_none, accept, resp_any_q;
    logic [COUNT_W-1:0] count_next, resp_count_q;
    logic [2*WIDTH-1:0] drive_lines;

    assign accept = bus.cmd_valid && (state == ST_IDLE);

    capp_priority_resolver #(.WORDS(WORDS)) u_resolver (
        .tags        (tags),
        .first_onehot(first_onehot),
        .none        (tags_none)
    );

    // Even line asserts a 1 at bit j, odd line a 0; masked-off bits drive neither.
    for (genvar j = 0; j < WIDTH; j++) begin : g_lines
        assign drive_lines[2*j]   = mask_q[j] &  data_q[j];
        assign drive_lines[2*j+1] = mask_q[j] & ~data_q[j];
    end

    always_ff @(posedge clk) begin : state_reg
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin : next_state
        // NOTE: default assignment first, so no path leaves the signal unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE:   if (accept) state_next = ST_DRIVE;
            ST_DRIVE:  state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        bus.cmd_ready      = (state == ST_IDLE);
        bus.resp_valid     = (state == ST_RESP);
        bus.mismatch_lines = '0;
        bus.write_lines    = '0;
        bus.word_select    = '0;
        unique case (op_q)
            OP_SEARCH:
                if (state == ST_DRIVE || state == ST_SAMPLE) bus.mismatch_lines = drive_lines;
            OP_WRITE:
                if (state == ST_DRIVE) begin
                    bus.write_lines = drive_lines;
                    bus.word_select = tags;
                end
            OP_READ_FIRST:
                if (state == ST_DRIVE || state == ST_SAMPLE) bus.word_select = first_onehot;
            OP_CLEAR_FIRST: ;
        endcase
    end

    always_comb begin : tag_update
        tags_next = tags;
        if (state == ST_SAMPLE) begin
            case (op_q)
                OP_SEARCH:      tags_next = ~bus.match_lines;
                OP_CLEAR_FIRST: tags_next = tags & ~first_onehot;
                default:        ;
            endcase
        end
    end

`ifdef CAPP_RESP_COUNT_EN
    // One spare bit beyond the count width keeps the saturation compare meaningful.
    localparam int POP_W = ($clog2(WORDS + 1) > COUNT_W) ? $clog2(WORDS + 1) : COUNT_W + 1;
    logic [POP_W-1:0] pop;

    always_comb begin : popcount
        pop = '0;
        for (int i = 0; i < WORDS; i++) pop = pop + POP_W'(tags_next[i]);
        count_next = (pop > POP_W'(COUNT_MAX)) ? COUNT_MAX : pop[COUNT_W-1:0];
    end
`else
    assign count_next = '0;
`endif

    always_ff @(posedge clk) begin : datapath
        if (!rst_n) begin
            op_q         <= OP_SEARCH;
            data_q       <= '0;
            mask_q       <= '0;
            tags         <= '0;
            resp_data_q  <= '0;
            resp_any_q   <= 1'b0;
            resp_count_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= capp_op_e'(bus.cmd_op);
                data_q <= bus.cmd_data;
                mask_q <= bus.cmd_mask;
            end
            tags <= tags_next;
            // Response fields settle on the SAMPLE edge and hold until the next command's.
            if (state == ST_SAMPLE) begin
                resp_data_q  <= (op_q == OP_READ_FIRST && !tags_none) ? bus.read_lines : '0;
                resp_any_q   <= |tags_next;
                resp_count_q <= count_next;
            end
        end
    end

    assign bus.resp_data  = resp_data_q;
    assign bus.resp_any   = resp_any_q;
    assign bus.resp_count = resp_count_q;

endmodule

// File: tb/tb_capp_controller.sv
// Self-checking bench: behavioural cell array, directed vector table, reset abort, random ops vs model.
module tb_capp_controller;
    import capp_pkg::*;

    localparam int LINES = 2 * WIDTH;
    localparam logic [WORDS-1:0] BIT1 = WORDS'(1) << 1;
    localparam logic [WORDS-1:0] BIT5 = WORDS'(1) << 5;
    typedef logic [127:0] wide_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    capp_controller_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus ();
    capp_controller #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural cell array ----------------
    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] load_image [WORDS];
    logic             load_en = 1'b0;
    logic [WIDTH-1:0] set_bits, clr_bits, want1, want0, read_model;
    logic [WORDS-1:0] match_model;

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            set_bits[j] = bus.write_lines[2*j];
            clr_bits[j] = bus.write_lines[2*j+1];
            want1[j]    = bus.mismatch_lines[2*j];
            want0[j]    = bus.mismatch_lines[2*j+1];
        end
    end

    always_comb begin
        match_model = '0;
        read_model  = '0;
        for (int w = 0; w < WORDS; w++) begin
            match_model[w] = |((~mem[w] & want1) | (mem[w] & want0));
            if (bus.word_select[w]) read_model = read_model | mem[w];
        end
    end

    assign bus.match_lines = match_model;
    assign bus.read_lines  = read_model;

    always @(posedge clk) begin
        for (int w = 0; w < WORDS; w++) begin
            if (load_en)                 mem[w] <= load_image[w];
            else if (bus.word_select[w]) mem[w] <= (mem[w] | set_bits) & ~clr_bits;
        end
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] ref_mem [WORDS];
    logic [WORDS-1:0] ref_tags = '0;

    function automatic int lowest_tag();
        for (int w = 0; w < WORDS; w++) if (ref_tags[w]) return w;
        return -1;
    endfunction

    function automatic logic [6:0] count_of(input int n);
        logic [6:0] c;
        c = (n > 127) ? 7'd127 : 7'(n);
`ifndef CAPP_RESP_COUNT_EN
        c = 7'd0;
`endif
        return c;
    endfunction

    function automatic logic [LINES-1:0] line_pattern(input logic [WIDTH-1:0] data, mask);
        logic [LINES-1:0] p;
        for (int j = 0; j < WIDTH; j++) begin
            p[2*j]   = mask[j] &  data[j];
            p[2*j+1] = mask[j] & ~data[j];
        end
        return p;
    endfunction

    task automatic model_cmd(input capp_op_e op, input logic [WIDTH-1:0] data, mask,
                             output logic [WIDTH-1:0] exp_data);
        int first;
        first    = lowest_tag();
        exp_data = '0;
        case (op)
            OP_SEARCH:
                for (int w = 0; w < WORDS; w++) ref_tags[w] = (((ref_mem[w] ^ data) & mask) == '0);
            OP_WRITE:
                for (int w = 0; w < WORDS; w++)
                    if (ref_tags[w]) ref_mem[w] = (ref_mem[w] & ~mask) | (data & mask);
            OP_READ_FIRST:
                if (first >= 0) exp_data = ref_mem[first];
            OP_CLEAR_FIRST:
                if (first >= 0) ref_tags[first] = 1'b0;
        endcase
    endtask

    task automatic preload();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        for (int w = 0; w < WORDS; w++) ref_mem[w] = load_image[w];
    endtask

    // ---------------- command driver / observer ----------------
    typedef struct {
        int               lat;
        logic [WIDTH-1:0] rdata;
        logic             any;
        logic [6:0]       cnt;
        logic [WORDS-1:0] sel_d, sel_s;
        logic [LINES-1:0] wl_d, wl_s, wl_r, ml_d, ml_s;
        logic             valid_after;
    } obs_t;
    obs_t obs;

    task automatic run_cmd(input capp_op_e op, input logic [WIDTH-1:0] data, mask);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_idle", wide_t'(bus.cmd_ready), wide_t'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_mask  = mask;
        @(posedge clk);
        #1;
        // Fields must already be captured; scramble them for the rest of the command.
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = WIDTH'($urandom);
        bus.cmd_mask  = WIDTH'($urandom);
        obs.lat = 0;
        for (int c = 1; c <= 6 && obs.lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                obs.sel_d = bus.word_select;
                obs.wl_d  = bus.write_lines;
                obs.ml_d  = bus.mismatch_lines;
            end
            if (c == 2) begin
                obs.sel_s = bus.word_select;
                obs.wl_s  = bus.write_lines;
                obs.ml_s  = bus.mismatch_lines;
            end
            if (bus.resp_valid) begin
                obs.lat   = c;
                obs.rdata = bus.resp_data;
                obs.any   = bus.resp_any;
                obs.cnt   = bus.resp_count;
                obs.wl_r  = bus.write_lines;
            end
        end
        @(negedge clk);
        obs.valid_after = bus.resp_valid;
    endtask

    typedef struct {
        capp_op_e         op;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] exp_data;
        logic             exp_any;
        int               exp_pop;
        logic [WORDS-1:0] exp_sel;
    } vec_t;
    vec_t vec [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, expected completion before time limit");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] exp_data;
        logic [WORDS-1:0] exp_sel;
        logic [LINES-1:0] exp_ml;
        int               first, bad, saw_valid;
        capp_op_e         op;
        logic [WIDTH-1:0] data, mask;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;

        vec[0]  = '{OP_SEARCH,      32'd457,        '1,    32'd0,   1'b1, 2,     '0};
        vec[1]  = '{OP_READ_FIRST,  32'd0,          32'd0, 32'd457, 1'b1, 2,     BIT1};
        vec[2]  = '{OP_CLEAR_FIRST, 32'd0,          32'd0, 32'd0,   1'b1, 1,     '0};
        vec[3]  = '{OP_READ_FIRST,  32'd0,          32'd0, 32'd457, 1'b1, 1,     BIT5};
        vec[4]  = '{OP_SEARCH,      32'd457,        '1,    32'd0,   1'b1, 2,     '0};
        vec[5]  = '{OP_WRITE,       32'd0,          32'd1, 32'd0,   1'b1, 2,     BIT1 | BIT5};
        vec[6]  = '{OP_READ_FIRST,  32'd0,          32'd0, 32'd456, 1'b1, 2,     BIT1};
        vec[7]  = '{OP_SEARCH,      32'hFFFF_FFFF,  32'd0, 32'd0,   1'b1, WORDS, '0};
        vec[8]  = '{OP_SEARCH,      32'hDEAD_BEEF,  '1,    32'd0,   1'b0, 0,     '0};
        vec[9]  = '{OP_READ_FIRST,  32'd0,          32'd0, 32'd0,   1'b0, 0,     '0};
        vec[10] = '{OP_CLEAR_FIRST, 32'd0,          32'd0, 32'd0,   1'b0, 0,     '0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready",   wide_t'(bus.cmd_ready),      wide_t'(1));
        check("rst_resp_valid",  wide_t'(bus.resp_valid),     wide_t'(0));
        check("rst_mismatch",    wide_t'(bus.mismatch_lines), wide_t'(0));
        check("rst_write_lines", wide_t'(bus.write_lines),    wide_t'(0));
        check("rst_word_select", wide_t'(bus.word_select),    wide_t'(0));
        check("rst_resp_data",   wide_t'(bus.resp_data),      wide_t'(0));
        check("rst_resp_any",    wide_t'(bus.resp_any),       wide_t'(0));
        check("rst_resp_count",  wide_t'(bus.resp_count),     wide_t'(0));

        for (int w = 0; w < WORDS; w++) load_image[w] = '0;
        load_image[0] = 32'd456;
        load_image[1] = 32'd457;
        load_image[4] = 32'd1000;
        load_image[5] = 32'd457;
        preload();
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_cmd(vec[i].op, vec[i].data, vec[i].mask);
            exp_ml = (vec[i].op == OP_SEARCH) ? line_pattern(vec[i].data, vec[i].mask) : '0;
            check($sformatf("v%0d_latency", i),     wide_t'(obs.lat),         wide_t'(3));
            check($sformatf("v%0d_resp_data", i),   wide_t'(obs.rdata),       wide_t'(vec[i].exp_data));
            check($sformatf("v%0d_resp_any", i),    wide_t'(obs.any),         wide_t'(vec[i].exp_any));
            check($sformatf("v%0d_resp_count", i),  wide_t'(obs.cnt),         wide_t'(count_of(vec[i].exp_pop)));
            check($sformatf("v%0d_sel_drive", i),   wide_t'(obs.sel_d),       wide_t'(vec[i].exp_sel));
            check($sformatf("v%0d_sel_sample", i),  wide_t'(obs.sel_s),
                  wide_t'((vec[i].op == OP_READ_FIRST) ? vec[i].exp_sel : '0));
            check($sformatf("v%0d_wl_drive", i),    wide_t'(obs.wl_d),
                  wide_t'((vec[i].op == OP_WRITE) ? line_pattern(vec[i].data, vec[i].mask) : '0));
            check($sformatf("v%0d_wl_sample", i),   wide_t'(obs.wl_s),        wide_t'(0));
            check($sformatf("v%0d_wl_resp", i),     wide_t'(obs.wl_r),        wide_t'(0));
            check($sformatf("v%0d_ml_drive", i),    wide_t'(obs.ml_d),        wide_t'(exp_ml));
            check($sformatf("v%0d_ml_sample", i),   wide_t'(obs.ml_s),        wide_t'(exp_ml));
            check($sformatf("v%0d_single_pulse", i), wide_t'(obs.valid_after), wide_t'(0));
        end
        check("write_clear_bit0_lines", wide_t'(line_pattern(32'd0, 32'd1)), wide_t'(2));

        // Reset asserted during the DRIVE cycle of a WRITE
        run_cmd(OP_SEARCH, 32'd456, '1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        bus.cmd_data  = '1;
        bus.cmd_mask  = '1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_wl_in_drive", wide_t'(bus.write_lines), wide_t'(line_pattern('1, '1)));
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_write_lines", wide_t'(bus.write_lines),    wide_t'(0));
        check("abort_mismatch",    wide_t'(bus.mismatch_lines), wide_t'(0));
        check("abort_word_select", wide_t'(bus.word_select),    wide_t'(0));
        check("abort_resp_valid",  wide_t'(bus.resp_valid),     wide_t'(0));
        check("abort_resp_any",    wide_t'(bus.resp_any),       wide_t'(0));
        check("abort_resp_count",  wide_t'(bus.resp_count),     wide_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid) saw_valid = 1;
        end
        check("abort_no_resp_valid", wide_t'(saw_valid),     wide_t'(0));
        check("abort_cmd_ready",     wide_t'(bus.cmd_ready), wide_t'(1));

        // Random commands against the reference model
        ref_tags = '0;
        for (int w = 0; w < WORDS; w++)
            load_image[w] = (w % 3 == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 7));
        preload();
        for (int k = 0; k < 80; k++) begin
            op = capp_op_e'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: mask = '1;
                1: mask = '0;
                2: mask = 32'h7;
                default: mask = WIDTH'($urandom);
            endcase
            data = ($urandom_range(0, 1) == 1) ? ref_mem[$urandom_range(0, WORDS - 1)]
                                               : WIDTH'($urandom_range(0, 7));
            first = lowest_tag();
            exp_sel = '0;
            if (op == OP_WRITE) exp_sel = ref_tags;
            if (op == OP_READ_FIRST && first >= 0) exp_sel = WORDS'(1) << first;
            model_cmd(op, data, mask, exp_data);
            run_cmd(op, data, mask);
            check($sformatf("r%0d_latency", k),    wide_t'(obs.lat),   wide_t'(3));
            check($sformatf("r%0d_resp_data", k),  wide_t'(obs.rdata), wide_t'(exp_data));
            check($sformatf("r%0d_resp_any", k),   wide_t'(obs.any),   wide_t'(|ref_tags));
            check($sformatf("r%0d_resp_count", k), wide_t'(obs.cnt),   wide_t'(count_of($countones(ref_tags))));
            check($sformatf("r%0d_sel_drive", k),  wide_t'(obs.sel_d), wide_t'(exp_sel));
        end
        bad = 0;
        for (int w = 0; w < WORDS; w++) if (mem[w] !== ref_mem[w]) bad++;
        check("array_contents_bad_words", wide_t'(bad), wide_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
